// File: rtl/lmul.sv
// Pipelined shift-add reconstructor: numerator = quotient * denominator + remainder, one stage per quotient bit.
// Optional LMUL_CHECK_EN adds invalid_out, flagging beats whose remainder/denominator pair is not a legal divider result.
module lmul #(
  parameter int NUMERATOR_WIDTH   = 10,
  parameter int DENOMINATOR_WIDTH = 10,
  parameter int QUOTIENT_WIDTH    = 10
) (
  input  logic                         clk,
  input  logic                         resetb,
  input  logic [QUOTIENT_WIDTH-1:0]    quotient_in,
  input  logic [DENOMINATOR_WIDTH-1:0] denominator_in,
  input  logic [NUMERATOR_WIDTH-1:0]   remainder_in,
  input  logic                         valid_in,
  output logic                         ready_in,
  output logic [NUMERATOR_WIDTH-1:0]   numerator_out,
  output logic                         overflow_out,
  output logic                         valid_out,
  input  logic                         ready_out
`ifdef LMUL_CHECK_EN
  ,
  output logic                         invalid_out
`endif
);

  localparam int ACC_W = QUOTIENT_WIDTH + DENOMINATOR_WIDTH + 1;

  // Handshake: a beat moves on a side when its valid and ready are both high in
  // the same cycle; the whole pipeline advances as one unit, so ready_in mirrors
  // the output side (free when the output slot is empty or being taken).
  logic advance;

  logic [ACC_W-1:0]             acc_q [0:QUOTIENT_WIDTH];
  logic [QUOTIENT_WIDTH-1:0]    quo_q [0:QUOTIENT_WIDTH-1];
  logic [DENOMINATOR_WIDTH-1:0] den_q [0:QUOTIENT_WIDTH-1];
  logic [QUOTIENT_WIDTH:0]      vld_q;
`ifdef LMUL_CHECK_EN
  logic [QUOTIENT_WIDTH:0]      chk_q;
`endif

  assign advance  = ready_out | ~valid_out;
  assign ready_in = advance;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      acc_q[0] <= '0;
      quo_q[0] <= '0;
      den_q[0] <= '0;
      vld_q[0] <= 1'b0;
    end else if (advance) begin
      acc_q[0] <= ACC_W'(remainder_in);
      quo_q[0] <= quotient_in;
      den_q[0] <= denominator_in;
      vld_q[0] <= valid_in;
    end
  end

`ifdef LMUL_CHECK_EN
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      chk_q[0] <= 1'b0;
    end else if (advance) begin
      chk_q[0] <= (denominator_in == '0) |
                  (ACC_W'(remainder_in) >= ACC_W'(denominator_in));
    end
  end
`endif

  for (genvar i = 1; i <= QUOTIENT_WIDTH; i++) begin : g_stage
    // Stage i folds in quotient bit i-1, weighting the denominator by 2^(i-1).
    always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
        acc_q[i] <= '0;
        vld_q[i] <= 1'b0;
      end else if (advance) begin
        acc_q[i] <= quo_q[i-1][i-1] ? acc_q[i-1] + (ACC_W'(den_q[i-1]) << (i-1))
                                    : acc_q[i-1];
        vld_q[i] <= vld_q[i-1];
      end
    end

    // The final stage only needs the accumulated sum, so operands stop one short.
    if (i < QUOTIENT_WIDTH) begin : g_pass
      always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
          quo_q[i] <= '0;
          den_q[i] <= '0;
        end else if (advance) begin
          quo_q[i] <= quo_q[i-1];
          den_q[i] <= den_q[i-1];
        end
      end
    end

`ifdef LMUL_CHECK_EN
    always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
        chk_q[i] <= 1'b0;
      end else if (advance) begin
        chk_q[i] <= chk_q[i-1];
      end
    end
`endif
  end

  assign numerator_out = acc_q[QUOTIENT_WIDTH][NUMERATOR_WIDTH-1:0];
  assign overflow_out  = |acc_q[QUOTIENT_WIDTH][ACC_W-1:NUMERATOR_WIDTH];
  assign valid_out     = vld_q[QUOTIENT_WIDTH];
`ifdef LMUL_CHECK_EN
  assign invalid_out   = chk_q[QUOTIENT_WIDTH];
`endif

endmodule

// File: tb/tb_lmul.sv
// Self-checking bench for lmul (N=4, D=3, Q=4, latency 5); checks invalid_out when LMUL_CHECK_EN is defined.
module tb_lmul;
  localparam int NW  = 4;
  localparam int DW  = 3;
  localparam int QW  = 4;
  localparam int LAT = QW + 1;
  localparam int W   = NW + 2;

  logic          clk = 1'b0;
  logic          resetb = 1'b0;
  logic [QW-1:0] quotient_in;
  logic [DW-1:0] denominator_in;
  logic [NW-1:0] remainder_in;
  logic          valid_in;
  logic          ready_in;
  logic [NW-1:0] numerator_out;
  logic          overflow_out;
  logic          valid_out;
  logic          ready_out;
  logic          inv_mon;
  logic [W-1:0]  obs;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];
  int           t_q[$];

  always #5 clk = ~clk;

  lmul #(
    .NUMERATOR_WIDTH(NW),
    .DENOMINATOR_WIDTH(DW),
    .QUOTIENT_WIDTH(QW)
  ) dut (
    .clk(clk),
    .resetb(resetb),
    .quotient_in(quotient_in),
    .denominator_in(denominator_in),
    .remainder_in(remainder_in),
    .valid_in(valid_in),
    .ready_in(ready_in),
    .numerator_out(numerator_out),
    .overflow_out(overflow_out),
    .valid_out(valid_out),
    .ready_out(ready_out)
`ifdef LMUL_CHECK_EN
    ,
    .invalid_out(inv_mon)
`endif
  );

`ifndef LMUL_CHECK_EN
  assign inv_mon = 1'b0;
`endif

  // observed beat packed as {invalid, overflow, numerator}
  assign obs = {inv_mon, overflow_out, numerator_out};

  // Reference: plain integer arithmetic on the operands.
  function automatic logic [W-1:0] model(input int q, input int d, input int r);
    int   v;
    logic chk;
    v = q * d + r;
`ifdef LMUL_CHECK_EN
    chk = (d == 0) || (r >= d);
`else
    chk = 1'b0;
`endif
    return {chk, (v >= (1 << NW)), v[NW-1:0]};
  endfunction

  task automatic drive(input int q, input int d, input int r, input logic v);
    quotient_in    = q[QW-1:0];
    denominator_in = d[DW-1:0];
    remainder_in   = r[NW-1:0];
    valid_in       = v;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    resetb = 1'b0;
    ready_out = 1'b0;
    drive(0, 0, 0, 1'b0);
    #2;
    checks++;
    if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", obs); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetb = 1'b1;
    #1;
    checks++;
    if (ready_in !== 1'b1) begin errors++; $display("FAIL reset_ready_in got=%b exp=1", ready_in); end
    tick;
  endtask

  task automatic test_basic;
    ready_out = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c == 0) drive(2, 7, 1, 1'b1); else drive(0, 0, 0, 1'b0);
      @(negedge clk);
      checks++;
      if (valid_out !== (c == LAT)) begin
        errors++; $display("FAIL basic_valid cyc=%0d got=%b exp=%b", c, valid_out, (c == LAT));
      end
      if (c == LAT) begin
        checks++;
        if ({overflow_out, numerator_out} !== 5'd15) begin
          errors++; $display("FAIL basic_data got=%h exp=0f", {overflow_out, numerator_out});
        end
      end
      tick;
    end
  endtask

  task automatic test_overflow;
    ready_out = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c == 0) drive(3, 5, 1, 1'b1);
      else if (c == 1) drive(15, 7, 15, 1'b1);
      else drive(0, 0, 0, 1'b0);
      @(negedge clk);
      checks++;
      if (valid_out !== (c == LAT || c == LAT + 1)) begin
        errors++; $display("FAIL ovf_valid cyc=%0d got=%b", c, valid_out);
      end
      if (c == LAT) begin
        checks++;
        if ({overflow_out, numerator_out} !== 5'h10) begin
          errors++; $display("FAIL ovf_16 got=%h exp=10", {overflow_out, numerator_out});
        end
      end
      if (c == LAT + 1) begin
        checks++;
        if ({overflow_out, numerator_out} !== 5'h18) begin
          errors++; $display("FAIL ovf_120 got=%h exp=18", {overflow_out, numerator_out});
        end
      end
      tick;
    end
  endtask

  // Every numerator 0..15 with every divisor 1..7, divided here and streamed back-to-back.
  task automatic test_round_trip;
    int n, d;
    logic [W-1:0] e;
    exp_q.delete();
    t_q.delete();
    ready_out = 1'b1;
    for (int c = 0; c < 112 + LAT + 2; c++) begin
      n = c / 7;
      d = c % 7 + 1;
      if (c < 112) drive(n / d, d, n % d, 1'b1); else drive(0, 0, 0, 1'b0);
      @(negedge clk);
      if (valid_in && ready_in) begin
        exp_q.push_back({2'b00, n[NW-1:0]});
        t_q.push_back(c + LAT);
      end
      checks++;
      if (valid_out !== (t_q.size() > 0 && t_q[0] == c)) begin
        errors++; $display("FAIL rt_valid cyc=%0d got=%b", c, valid_out);
      end
      if (valid_out && ready_out) begin
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rt_extra cyc=%0d got=%h exp=none", c, obs);
        end else begin
          e = exp_q.pop_front();
          void'(t_q.pop_front());
          checks++;
          if (obs !== e) begin errors++; $display("FAIL rt_data cyc=%0d got=%h exp=%h", c, obs, e); end
        end
      end
      tick;
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rt_lost got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_backpressure;
    int k, outs;
    logic stall;
    logic [W-1:0] e;
    k = 0;
    outs = 0;
    exp_q.delete();
    for (int c = 0; c < 30; c++) begin
      stall = (c >= LAT && c < LAT + 6);
      ready_out = !stall;
      if (k < 8) drive(k + 1, k % 7 + 1, k, 1'b1); else drive(0, 0, 0, 1'b0);
      @(negedge clk);
      if (valid_in && ready_in) begin
        exp_q.push_back(model(k + 1, k % 7 + 1, k));
        k++;
      end
      if (stall) begin
        checks++;
        if (ready_in !== 1'b0) begin errors++; $display("FAIL bp_ready_in cyc=%0d got=%b exp=0", c, ready_in); end
        checks++;
        if (exp_q.size() == 0 || obs !== exp_q[0]) begin
          errors++; $display("FAIL bp_hold cyc=%0d got=%h", c, obs);
        end
      end
      if (c >= LAT && outs < 8) begin
        checks++;
        if (valid_out !== 1'b1) begin errors++; $display("FAIL bp_gap cyc=%0d got=%b exp=1", c, valid_out); end
      end
      if (valid_out && ready_out) begin
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL bp_extra cyc=%0d got=%h exp=none", c, obs);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (obs !== e) begin errors++; $display("FAIL bp_data cyc=%0d got=%h exp=%h", c, obs, e); end
        end
        outs++;
      end
      tick;
    end
    checks++;
    if (outs != 8) begin errors++; $display("FAIL bp_count got=%0d exp=8", outs); end
  endtask

  task automatic test_random;
    int q, d, r, outs, ins;
    logic [W-1:0] e;
    outs = 0;
    ins = 0;
    exp_q.delete();
    for (int c = 0; c < 260; c++) begin
      q = $urandom_range(0, 15);
      d = $urandom_range(0, 7);
      r = $urandom_range(0, 15);
      ready_out = (c >= 220) ? 1'b1 : ($urandom_range(0, 9) < 6);
      drive(q, d, r, (c < 220) && ($urandom_range(0, 9) < 7));
      @(negedge clk);
      checks++;
      if (ready_in !== (ready_out || !valid_out)) begin
        errors++; $display("FAIL rnd_ready_in cyc=%0d got=%b", c, ready_in);
      end
      if (valid_in && ready_in) begin
        exp_q.push_back(model(q, d, r));
        ins++;
      end
      if (valid_out && ready_out) begin
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rnd_extra cyc=%0d got=%h exp=none", c, obs);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (obs !== e) begin errors++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", c, obs, e); end
        end
        outs++;
      end
      tick;
    end
    checks++;
    if (outs != ins) begin errors++; $display("FAIL rnd_count got=%0d exp=%0d", outs, ins); end
  endtask

`ifdef LMUL_CHECK_EN
  task automatic test_check;
    ready_out = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c == 0) drive(1, 3, 5, 1'b1);
      else if (c == 1) drive(1, 0, 0, 1'b1);
      else if (c == 2) drive(1, 3, 2, 1'b1);
      else drive(0, 0, 0, 1'b0);
      @(negedge clk);
      if (c == LAT) begin
        checks++;
        if (obs !== 6'b10_1000) begin errors++; $display("FAIL chk_rge got=%h exp=28", obs); end
      end
      if (c == LAT + 1) begin
        checks++;
        if (obs !== 6'b10_0000) begin errors++; $display("FAIL chk_d0 got=%h exp=20", obs); end
      end
      if (c == LAT + 2) begin
        checks++;
        if (obs !== 6'b00_0101) begin errors++; $display("FAIL chk_ok got=%h exp=05", obs); end
      end
      tick;
    end
  endtask
`endif

  task automatic test_reset_mid_flight;
    ready_out = 1'b0;
    for (int c = 0; c < LAT + 1; c++) begin
      if (c < 3) drive(c + 1, 3, 1, 1'b1); else drive(0, 0, 0, 1'b0);
      tick;
    end
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got=%b exp=1", valid_out); end
    resetb = 1'b0;
    #1;
    checks++;
    if (valid_out !== 1'b0) begin errors++; $display("FAIL rst_async_valid got=%b exp=0", valid_out); end
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL rst_async_data got=%h exp=0", obs); end
    @(negedge clk);
    resetb = 1'b1;
    ready_out = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick;
      @(negedge clk);
      checks++;
      if (valid_out !== 1'b0) begin errors++; $display("FAIL rst_ghost cyc=%0d got=%b exp=0", c, valid_out); end
    end
    tick;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_round_trip();
    test_backpressure();
    test_random();
`ifdef LMUL_CHECK_EN
    test_check();
`endif
    test_reset_mid_flight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
